// File: rtl/spi_frame_pkg.sv
// Shared types and defaults for the serial frame transmitter.
// Holds the FSM state encoding and the counter-width helper.
package spi_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_e;

    localparam int FRAME_LEN_DEF = 16;
    localparam int GAP_LEN_DEF   = 1;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_frame_tx_if.sv
// Parallel word handshake between a word source and the transmitter.
interface spi_frame_tx_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/spi_frame_shreg.sv
// Parallel-load, shift-left register; MSB is the serial output.
module spi_frame_shreg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);
    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = {sr_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb = sr_q[W-1];
endmodule

// File: rtl/spi_frame_tx.sv
// Serial frame transmitter: ce high for FRAME_LEN clocks, data MSB-first.
// Define SPI_FRAME_TX_SVA_EN to compile in the framing assertions.
module spi_frame_tx
    import spi_frame_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int GAP_LEN   = GAP_LEN_DEF
) (
    input  logic           clk,
    input  logic           rst,
    spi_frame_tx_if.slave  bus,
    output logic           ce,
    output logic           sdo,
    output logic           busy,
    output logic           done
);
    localparam int CW = cnt_width(FRAME_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
    localparam logic [3:0]    GAP_LAST = 4'(GAP_LEN - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    gap_q, gap_d;
    logic          ce_q, ce_d;
    logic          done_q, done_d;
    logic          rdy_q, rdy_d;
    logic          load;
    logic          shift;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && rdy_q) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    gap_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they align with it
        ce_d   = (state_d == SHIFT);
        done_d = (state_q == SHIFT) && (state_d == GAP);
        rdy_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            ce_q    <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            ce_q    <= ce_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    spi_frame_shreg #(
        .W(FRAME_LEN)
    ) u_shreg (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .shift(shift),
        .din  (bus.in_data),
        .msb  (sdo)
    );

    assign ce           = ce_q;
    assign done         = done_q;
    assign busy         = (state_q != IDLE);
    assign bus.in_ready = rdy_q;

`ifdef SPI_FRAME_TX_SVA_EN
    a_frame: assert property (@(posedge clk) disable iff (rst)
        !ce ##1 ce |-> ce[*FRAME_LEN] ##1 !ce[*GAP_LEN])
        else $error("ce framing violated");

    a_done: assert property (@(posedge clk) disable iff (rst)
        done == ($fell(ce) && !$past(rst)))
        else $error("done not aligned with ce fall");

    a_excl: assert property (@(posedge clk) disable iff (rst)
        !(bus.in_ready && ce))
        else $error("in_ready and ce both high");
`endif
endmodule
